// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//    Measures an incoming PWM waveform. For each window between two accepted
//    rising edges it reports:
//       - the period
//       - the high time
//       - an 8-bit duty code floor(high*256/period), saturated to 255
//    The duty code uses the same scale as the PWM generator's width input.
//    A missing rising edge for TIMEOUT_CYCLES flags the input as stuck.
//
// Optional feature (macro PWM_CAPTURE_GLITCH_FILTER_EN):
//    Adds a glitch filter after the synchronizer. The conditioned input only
//    changes after the synchronized value has held for 4 consecutive cycles.
//    Both edges are delayed by 3 extra cycles, so widths are unchanged.
//
// Parameters:
//    TIMEOUT_CYCLES : cycles without a rising edge before o_stuck is raised
//    COUNT_WIDTH    : width of the period/high counters (must hold TIMEOUT)
//
// Ports:
//    i_fclk    : system clock
//    i_reset   : asynchronous reset, active-high
//    i_pwm_in  : asynchronous PWM input
//    o_period  : last measured period in cycles
//    o_high    : last measured high time in cycles
//    o_duty    : floor(o_high*256/o_period), saturated to 255
//    o_valid   : one-cycle pulse when period/high/duty update
//    o_stuck   : input held at one level for TIMEOUT_CYCLES
//    o_level   : level the input is stuck at (meaningful when o_stuck=1)
//    o_overrun : one-cycle pulse when a capture is dropped (divider busy)
// ---------------------------------------------------------------------------
module pwm_capture #(
   parameter int TIMEOUT_CYCLES = 2_560_000,
   parameter int COUNT_WIDTH    = 22
) (
   input  logic                   i_fclk,
   input  logic                   i_reset,
   input  logic                   i_pwm_in,
   output logic [COUNT_WIDTH-1:0] o_period,
   output logic [COUNT_WIDTH-1:0] o_high,
   output logic [7:0]             o_duty,
   output logic                   o_valid,
   output logic                   o_stuck,
   output logic                   o_level,
   output logic                   o_overrun
);

   localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] ONE_C     = COUNT_WIDTH'(1);
   localparam logic [3:0]             LAST_STEP_C = 4'd8;

   typedef enum logic [0:0] {
      S_WAIT_EDGE = 1'b0,
      S_MEASURE   = 1'b1
   } state_t;

   // Input conditioning
   logic sync1_r;
   logic sync2_r;
   logic pwm_s;
   logic pwm_prev_r;
   logic rise_r;

   // Measurement
   state_t                 state_r;
   logic [COUNT_WIDTH-1:0] period_cnt_r;
   logic [COUNT_WIDTH-1:0] high_cnt_r;
   logic [COUNT_WIDTH-1:0] cap_period_r;
   logic [COUNT_WIDTH-1:0] cap_high_r;

   // Divider
   logic                   div_busy_r;
   logic [3:0]             div_step_r;
   logic [COUNT_WIDTH:0]   div_rem_r;
   logic [COUNT_WIDTH-1:0] div_den_r;
   logic [8:0]             div_q_r;
   logic                   div_ge_s;
   logic [COUNT_WIDTH:0]   div_diff_s;
   logic [8:0]             div_q_next_s;
   logic [7:0]             duty_s;

   // Two-flop synchronizer for the asynchronous PWM pin
   always_ff @(posedge i_fclk or posedge i_reset) begin
      if (i_reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= i_pwm_in;
         sync2_r <= sync1_r;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic hist1_r;
   logic hist2_r;
   logic filt_r;

   // Glitch filter: accept a new level after 4 consecutive equal samples.
   // sync1_r is the next sync2_r sample. Using it as lookahead lets the
   // filter switch with 3 cycles of delay instead of 4.
   always_ff @(posedge i_fclk or posedge i_reset) begin
      if (i_reset) begin
         hist1_r <= 1'b0;
         hist2_r <= 1'b0;
         filt_r  <= 1'b0;
      end else begin
         hist1_r <= sync2_r;
         hist2_r <= hist1_r;
         if ((sync1_r == sync2_r) && (sync2_r == hist1_r) &&
             (hist1_r == hist2_r) && (sync1_r != filt_r)) begin
            filt_r <= sync1_r;
         end else begin
            filt_r <= filt_r;
         end
      end
   end

   assign pwm_s = filt_r;
`else
   assign pwm_s = sync2_r;
`endif

   // Rising-edge detect, registered (edge cycle is one after pwm_s rises)
   always_ff @(posedge i_fclk or posedge i_reset) begin
      if (i_reset) begin
         pwm_prev_r <= 1'b0;
         rise_r     <= 1'b0;
      end else begin
         pwm_prev_r <= pwm_s;
         rise_r     <= pwm_s & ~pwm_prev_r;
      end
   end

   // One restoring-division step. The remainder starts at high. Because
   // high <= period, nine compare/subtract/shift steps yield the quotient
   // bits of (high<<8)/period.
   always_comb begin
      div_ge_s = (div_rem_r >= {1'b0, div_den_r});
      if (div_ge_s) begin
         div_diff_s = div_rem_r - {1'b0, div_den_r};
      end else begin
         div_diff_s = div_rem_r;
      end
      div_q_next_s = {div_q_r[7:0], div_ge_s};
      if (div_q_next_s[8]) begin
         duty_s = 8'hFF;
      end else begin
         duty_s = div_q_next_s[7:0];
      end
   end

   // Measurement FSM, counters, divider sequencing and registered outputs
   always_ff @(posedge i_fclk or posedge i_reset) begin
      if (i_reset) begin
         state_r      <= S_WAIT_EDGE;
         period_cnt_r <= '0;
         high_cnt_r   <= '0;
         cap_period_r <= '0;
         cap_high_r   <= '0;
         div_busy_r   <= 1'b0;
         div_step_r   <= 4'd0;
         div_rem_r    <= '0;
         div_den_r    <= '0;
         div_q_r      <= 9'd0;
         o_period     <= '0;
         o_high       <= '0;
         o_duty       <= 8'd0;
         o_valid      <= 1'b0;
         o_stuck      <= 1'b0;
         o_level      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;

         // Divider: steps 0..8 run on the cycles after the capture. Step 8
         // also publishes, so o_valid appears 10 cycles after the edge.
         if (div_busy_r) begin
            div_rem_r <= {div_diff_s[COUNT_WIDTH-1:0], 1'b0};
            div_q_r   <= div_q_next_s;
            if (div_step_r == LAST_STEP_C) begin
               div_busy_r <= 1'b0;
               o_period   <= cap_period_r;
               o_high     <= cap_high_r;
               o_duty     <= duty_s;
               o_valid    <= 1'b1;
               o_stuck    <= 1'b0;
            end else begin
               div_step_r <= div_step_r + 4'd1;
            end
         end else begin
            div_step_r <= div_step_r;
         end

         case (state_r)
            S_WAIT_EDGE: begin
               // First edge only arms the counters; no capture is made.
               if (rise_r) begin
                  period_cnt_r <= ONE_C;
                  high_cnt_r   <= ONE_C;
                  state_r      <= S_MEASURE;
               end else begin
                  state_r <= S_WAIT_EDGE;
               end
            end
            S_MEASURE: begin
               // The edge is checked first, so it beats a same-cycle timeout.
               if (rise_r) begin
                  period_cnt_r <= ONE_C;
                  high_cnt_r   <= ONE_C;
                  if (div_busy_r) begin
                     o_overrun <= 1'b1;
                  end else begin
                     cap_period_r <= period_cnt_r;
                     cap_high_r   <= high_cnt_r;
                     div_rem_r    <= {1'b0, high_cnt_r};
                     div_den_r    <= period_cnt_r;
                     div_q_r      <= 9'd0;
                     div_step_r   <= 4'd0;
                     div_busy_r   <= 1'b1;
                  end
               end else if (period_cnt_r == TIMEOUT_C) begin
                  o_stuck  <= 1'b1;
                  o_level  <= pwm_s;
                  o_period <= '0;
                  o_high   <= '0;
                  if (pwm_s) begin
                     o_duty <= 8'hFF;
                  end else begin
                     o_duty <= 8'h00;
                  end
                  o_valid <= 1'b1;
                  state_r <= S_WAIT_EDGE;
               end else begin
                  period_cnt_r <= period_cnt_r + ONE_C;
                  if (pwm_s) begin
                     high_cnt_r <= high_cnt_r + ONE_C;
                  end else begin
                     high_cnt_r <= high_cnt_r;
                  end
               end
            end
            default: begin
               state_r <= S_WAIT_EDGE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//    Drives PWM patterns into pwm_capture (TIMEOUT_CYCLES=1000, COUNT_WIDTH=10).
//    The driver predicts every capture, timeout and overrun from the waveform
//    it generates and pushes each prediction to a queue. A negedge monitor
//    pops the queue and compares whenever o_valid or o_overrun fires.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_capture;

   localparam int TO = 1000;
   localparam int CW = 10;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT  = 6;
   localparam int TR_H = 4;
   localparam int TR_L = 4;
   localparam int HI_H = 296;
   localparam int HI_L = 4;
`else
   localparam int LAT  = 3;
   localparam int TR_H = 3;
   localparam int TR_L = 3;
   localparam int HI_H = 299;
   localparam int HI_L = 1;
`endif

   logic          i_fclk = 1'b0;
   logic          i_reset;
   logic          i_pwm_in;
   logic [CW-1:0] o_period;
   logic [CW-1:0] o_high;
   logic [7:0]    o_duty;
   logic          o_valid;
   logic          o_stuck;
   logic          o_level;
   logic          o_overrun;

   pwm_capture #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
      .i_fclk    (i_fclk),
      .i_reset   (i_reset),
      .i_pwm_in  (i_pwm_in),
      .o_period  (o_period),
      .o_high    (o_high),
      .o_duty    (o_duty),
      .o_valid   (o_valid),
      .o_stuck   (o_stuck),
      .o_level   (o_level),
      .o_overrun (o_overrun)
   );

   always #5 i_fclk = ~i_fclk;

   int cyc = 0;
   always @(posedge i_fclk) cyc <= cyc + 1;

   typedef struct {
      int t;
      int period;
      int high;
      int duty;
      bit stuck;
      bit level;
   } exp_t;

   exp_t sb_q[$];
   int   ov_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   // reference model state
   bit armed;
   int last_e;
   int last_acc;
   int prev_high;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_fclk);
         #1;
      end
   endtask

   task automatic model_reset();
      armed    = 1'b0;
      last_e   = 0;
      last_acc = -1000;
      prev_high = 0;
   endtask

   // e: cycle in which the DUT sees the edge; h_this: width of the new pulse
   task automatic model_edge(input int e, input int h_this);
      exp_t ex;
      if (!armed) begin
         armed = 1'b1;
      end else if (e < last_acc + 10) begin
         ov_q.push_back(e + 1);
      end else begin
         ex.t      = e + 10;
         ex.period = e - last_e;
         ex.high   = prev_high;
         ex.duty   = (prev_high * 256) / (e - last_e);
         if (ex.duty > 255) ex.duty = 255;
         ex.stuck  = 1'b0;
         ex.level  = 1'b0;
         sb_q.push_back(ex);
         last_acc = e;
      end
      last_e    = e;
      prev_high = h_this;
   endtask

   // One PWM period starting with a rising edge now; the next edge follows h+l later
   task automatic pulse(input int h, input int l);
      exp_t ex;
      i_pwm_in = 1'b1;
      model_edge(cyc + LAT, h);
      if (h + l > TO) begin
         ex.t      = last_e + TO + 1;
         ex.period = 0;
         ex.high   = 0;
         ex.level  = (h >= TO + 2);
         ex.duty   = ex.level ? 255 : 0;
         ex.stuck  = 1'b1;
         sb_q.push_back(ex);
         armed = 1'b0;
      end
      tick(h);
      i_pwm_in = 1'b0;
      tick(l);
   endtask

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   // 256-cycle period with a 2-cycle low glitch inside the 64-cycle high
   task automatic pulse_glitch();
      i_pwm_in = 1'b1;
      model_edge(cyc + LAT, 64);
      tick(30);
      i_pwm_in = 1'b0;
      tick(2);
      i_pwm_in = 1'b1;
      tick(32);
      i_pwm_in = 1'b0;
      tick(192);
   endtask
`endif

   exp_t mon_ex;
   int   mon_t;

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge i_fclk) begin
      if (i_reset === 1'b0) begin
         if (o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               check_val("unexpected_valid", o_valid, 0);
            end else begin
               mon_ex = sb_q.pop_front();
               check_val("valid_time", cyc, mon_ex.t);
               check_val("period", o_period, mon_ex.period);
               check_val("high", o_high, mon_ex.high);
               check_val("duty", o_duty, mon_ex.duty);
               check_val("stuck", o_stuck, mon_ex.stuck);
               if (mon_ex.stuck) check_val("level", o_level, mon_ex.level);
            end
         end
         if (o_overrun === 1'b1) begin
            if (ov_q.size() == 0) begin
               check_val("unexpected_overrun", o_overrun, 0);
            end else begin
               mon_t = ov_q.pop_front();
               check_val("overrun_time", cyc, mon_t);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      i_reset  = 1'b1;
      i_pwm_in = 1'b0;
      model_reset();
      #12;
      check_val("reset_outputs",
                {o_period, o_high, o_duty, o_valid, o_stuck, o_level, o_overrun}, 0);
      tick(1);
      i_reset = 1'b0;
      tick(2);

      // held low from reset: never armed, no stuck
      tick(1200);
      check_val("stuck_never_armed", o_stuck, 0);

      // single edge then low -> stuck at 0
      pulse(20, 1100);
      check_val("stuck_low_flag", o_stuck, 1);
      check_val("stuck_low_level", o_level, 0);

      // period 256, high 64; first edge re-arms, later edges capture
      repeat (4) pulse(64, 192);
      check_val("stuck_cleared", o_stuck, 0);

      // period 300: high 100 then near-full high
      repeat (3) pulse(100, 200);
      repeat (3) pulse(HI_H, HI_L);

      // stuck high after two edges, then recovery
      pulse(64, 192);
      pulse(1100, 50);
      check_val("stuck_high_flag", o_stuck, 1);
      check_val("stuck_high_level", o_level, 1);
      pulse(64, 192);
      check_val("stuck_held_rearm", o_stuck, 1);
      repeat (2) pulse(64, 192);
      check_val("stuck_recovered", o_stuck, 0);

      // too-fast pulse train -> overruns, then normal captures resume
      pulse(64, 192);
      repeat (8) pulse(TR_H, TR_L);
      repeat (3) pulse(64, 192);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      pulse(64, 192);
      pulse_glitch();
      repeat (2) pulse(64, 192);
`endif

      // reset mid-period: outputs clear at once, two edges needed afterwards
      repeat (2) pulse(64, 192);
      pulse(64, 40);
      check_val("pre_reset_period", o_period, 256);
      #3;
      i_reset = 1'b1;
      #1;
      check_val("midreset_outputs",
                {o_period, o_high, o_duty, o_valid, o_stuck, o_level, o_overrun}, 0);
      model_reset();
      tick(5);
      i_reset = 1'b0;
      tick(20);
      repeat (3) pulse(64, 192);
      tick(20);

      check_val("sb_leftover", sb_q.size(), 0);
      check_val("overrun_leftover", ov_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
